vga_board_update_ctrl: RTL and testbench

- Frame-synchronised update controller between the 2048 game logic and the VGA board renderer.
- Game logic writes to a 64-bit shadow board through two requester ports: full-board load and single-tile write.
- The controller arbitrates the two ports and commits the shadow to the displayed `board_state` only at the start of vertical blanking, so the renderer never shows a torn frame.
- Drives the renderer's `board_state` input directly, and takes `hc`/`vc` from the 640x480 timing counters.

---
 rtl/vga_board_update_ctrl_if.sv | 23 ++
 rtl/vga_board_update_ctrl.sv | 93 +++++++++
 tb/tb_vga_board_update_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_board_update_ctrl_if.sv
// Write-side bus between the 2048 game logic and the board update controller.
//   load_valid/load_data/load_ready : full-board load, nibble i at bits i*4+:4
//   tile_valid/tile_idx/tile_val/tile_ready : single-tile write (idx = row*4+col)
// master = game logic, slave = update controller.
interface vga_board_update_ctrl_if;
  logic        load_valid;
  logic [0:63] load_data;
  logic        load_ready;
  logic        tile_valid;
  logic [3:0]  tile_idx;
  logic [3:0]  tile_val;
  logic        tile_ready;

  modport master (
    output load_valid, load_data, tile_valid, tile_idx, tile_val,
    input  load_ready, tile_ready
  );

  modport slave (
    input  load_valid, load_data, tile_valid, tile_idx, tile_val,
    output load_ready, tile_ready
  );
endinterface

// File: rtl/vga_board_update_ctrl.sv
// Frame-synchronised board update controller.
// Game logic writes a shadow board through the bus (full load or single tile,
// load has priority). The shadow is copied to board_state only in the single
// COMMIT cycle that follows the first front-porch line start, so the renderer
// never sees a half-updated board.
// Ports:
//   dclk, clr_n   pixel clock, async active-low reset
//   hc, vc        timing generator counters
//   bus           write requests (slave side)
//   board_state   displayed board to renderer
//   commit_pulse  high during the COMMIT cycle
//   pending       shadow differs from display
//   val_err       sticky flag: a tile code above MAX_TILE was clamped
module vga_board_update_ctrl #(
  parameter int VFP_LINE = 511,
  parameter int MAX_TILE = 11
) (
  input  logic                     dclk,
  input  logic                     clr_n,
  input  logic [9:0]               hc,
  input  logic [9:0]               vc,
  vga_board_update_ctrl_if.slave   bus,
  output logic [0:63]              board_state,
  output logic                     commit_pulse,
  output logic                     pending,
  output logic                     val_err
);

  localparam logic [3:0] MAX_CODE = 4'(MAX_TILE);

  typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;

  state_t      state, state_n;
  logic [0:63] shadow;
  logic [0:63] load_clamped;
  logic [15:0] load_over;
  logic [3:0]  tile_clamped;
  logic        tile_over;
  logic        load_acc, tile_acc;
  logic        commit_pt;

  // Per-nibble clamp of the incoming full board.
  for (genvar i = 0; i < 16; i++) begin : g_clamp
    assign load_over[i]          = bus.load_data[i*4 +: 4] > MAX_CODE;
    assign load_clamped[i*4 +: 4] = load_over[i] ? MAX_CODE : bus.load_data[i*4 +: 4];
  end

  assign tile_over    = bus.tile_val > MAX_CODE;
  assign tile_clamped = tile_over ? MAX_CODE : bus.tile_val;

  // Readys are forced low while reset is held, not just by the reset state.
  assign bus.load_ready = clr_n && (state != COMMIT);
  assign bus.tile_ready = clr_n && (state != COMMIT) && !bus.load_valid;

  assign load_acc  = bus.load_valid && bus.load_ready;
  assign tile_acc  = bus.tile_valid && bus.tile_ready;
  assign commit_pt = (vc == 10'(VFP_LINE)) && (hc == '0);

  assign commit_pulse = (state == COMMIT);
  assign pending      = (state != IDLE);

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_n;
  end

  // A write landing in IDLE on the commit-point cycle only reaches DIRTY,
  // so it waits for the next frame's commit point.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load_acc || tile_acc) state_n = DIRTY;
      DIRTY:   if (commit_pt)            state_n = COMMIT;
      COMMIT:                            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      shadow      <= '0;
      board_state <= '0;
      val_err     <= 1'b0;
    end else begin
      if (load_acc)      shadow <= load_clamped;
      else if (tile_acc) shadow[{bus.tile_idx, 2'b00} +: 4] <= tile_clamped;
      // No writes are accepted in COMMIT, so shadow is stable here.
      if (state == COMMIT) board_state <= shadow;
      if ((load_acc && |load_over) || (tile_acc && tile_over)) val_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_board_update_ctrl.sv
module tb_vga_board_update_ctrl;
  logic        dclk = 1'b0;
  logic        clr_n;
  logic [9:0]  hc, vc;
  logic [0:63] board_state;
  logic        commit_pulse, pending, val_err;
  int          tests = 0;
  int          fails = 0;

  vga_board_update_ctrl_if bus();

  vga_board_update_ctrl #(.VFP_LINE(511), .MAX_TILE(11)) dut (
    .dclk(dclk), .clr_n(clr_n), .hc(hc), .vc(vc), .bus(bus),
    .board_state(board_state), .commit_pulse(commit_pulse),
    .pending(pending), .val_err(val_err)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  // Drive the commit point, check the COMMIT cycle, then close it.
  task automatic do_commit(input logic [63:0] exp_board);
    vc = 10'd511; hc = 10'd0;
    tick();
    chk("commit_pulse_hi", commit_pulse, 1);
    chk("load_ready_commit", bus.load_ready, 0);
    chk("tile_ready_commit", bus.tile_ready, 0);
    hc = 10'd1;
    tick();
    chk("commit_pulse_lo", commit_pulse, 0);
    chk("pending_after_commit", pending, 0);
    chk("board_after_commit", board_state, exp_board);
  endtask

  initial begin
    clr_n = 1'b0; hc = '0; vc = '0;
    bus.load_valid = 1'b0; bus.load_data = '0;
    bus.tile_valid = 1'b0; bus.tile_idx = '0; bus.tile_val = '0;
    #1;
    chk("rst_board", board_state, 0);
    chk("rst_pending", pending, 0);
    chk("rst_pulse", commit_pulse, 0);
    chk("rst_val_err", val_err, 0);
    chk("rst_load_ready", bus.load_ready, 0);
    chk("rst_tile_ready", bus.tile_ready, 0);
    tick(); tick();
    clr_n = 1'b1;
    #1;
    chk("idle_load_ready", bus.load_ready, 1);
    chk("idle_tile_ready", bus.tile_ready, 1);

    // Idle across two commit points: nothing happens.
    for (int f = 0; f < 2; f++) begin
      vc = 10'd511; hc = 10'd0;
      tick();
      chk("idle_no_pulse_a", commit_pulse, 0);
      hc = 10'd1;
      tick();
      chk("idle_no_pulse_b", commit_pulse, 0);
    end
    chk("idle_board", board_state, 0);
    chk("idle_pending", pending, 0);

    // Single tile write, idx 5 = 1.
    vc = 10'd100; hc = 10'd3;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd5; bus.tile_val = 4'd1;
    #1;
    chk("tile_ready_idle", bus.tile_ready, 1);
    tick();
    bus.tile_valid = 1'b0;
    chk("tile_pending", pending, 1);
    chk("tile_board_unchanged", board_state, 0);
    do_commit(64'h0000_0100_0000_0000);
    chk("tile_nibble5", board_state[20:23], 4'd1);

    // Collision: load wins, tile follows and overlays nibble 2.
    vc = 10'd200; hc = 10'd0;
    bus.load_valid = 1'b1; bus.load_data = 64'h1234_5678_9AB0_1234;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd2; bus.tile_val = 4'd7;
    #1;
    chk("coll_load_ready", bus.load_ready, 1);
    chk("coll_tile_ready", bus.tile_ready, 0);
    tick();
    bus.load_valid = 1'b0;
    #1;
    chk("coll_tile_ready_next", bus.tile_ready, 1);
    tick();
    bus.tile_valid = 1'b0;
    chk("coll_board_held", board_state, 64'h0000_0100_0000_0000);
    do_commit(64'h1274_5678_9AB0_1234);
    chk("coll_val_err", val_err, 0);

    // Tile clamp: 15 -> 11 at idx 0.
    vc = 10'd10; hc = 10'd0;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd0; bus.tile_val = 4'd15;
    tick();
    bus.tile_valid = 1'b0;
    chk("clamp_val_err", val_err, 1);
    do_commit(64'hB274_5678_9AB0_1234);

    // Load clamp: F and C nibbles become B.
    vc = 10'd20;
    bus.load_valid = 1'b1; bus.load_data = 64'hF0C0_0000_0000_0005;
    tick();
    bus.load_valid = 1'b0;
    do_commit(64'hB0B0_0000_0000_0005);
    chk("val_err_sticky", val_err, 1);

    // Write in IDLE exactly at the commit point: deferred a frame.
    vc = 10'd511; hc = 10'd0;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd15; bus.tile_val = 4'd3;
    tick();
    bus.tile_valid = 1'b0;
    hc = 10'd1;
    chk("edge_idle_no_pulse", commit_pulse, 0);
    chk("edge_idle_pending", pending, 1);
    tick();
    chk("edge_idle_no_pulse2", commit_pulse, 0);
    chk("edge_idle_board_held", board_state, 64'hB0B0_0000_0000_0005);
    // Next frame: write in DIRTY at the commit point is included.
    vc = 10'd511; hc = 10'd0;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd14; bus.tile_val = 4'd4;
    tick();
    bus.tile_valid = 1'b0;
    chk("edge_dirty_pulse", commit_pulse, 1);
    hc = 10'd1;
    tick();
    chk("edge_dirty_board", board_state, 64'hB0B0_0000_0000_0043);
    chk("edge_dirty_pending", pending, 0);

    // Async reset in the middle of COMMIT.
    vc = 10'd50; hc = 10'd0;
    bus.tile_valid = 1'b1; bus.tile_idx = 4'd1; bus.tile_val = 4'd2;
    tick();
    bus.tile_valid = 1'b0;
    vc = 10'd511; hc = 10'd0;
    tick();
    chk("mid_rst_pulse_before", commit_pulse, 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_board", board_state, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_pulse", commit_pulse, 0);
    chk("mid_rst_val_err", val_err, 0);
    chk("mid_rst_load_ready", bus.load_ready, 0);
    chk("mid_rst_tile_ready", bus.tile_ready, 0);
    tick();
    clr_n = 1'b1;
    hc = 10'd1;
    tick();
    chk("post_rst_pulse", commit_pulse, 0);
    chk("post_rst_board", board_state, 0);
    vc = 10'd511; hc = 10'd0;
    tick();
    chk("post_rst_no_commit", commit_pulse, 0);
    hc = 10'd1;
    tick();
    chk("post_rst_board2", board_state, 0);
    chk("post_rst_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
